imem_loader: RTL
================

# imem_loader

Boot-time loader that sits directly upstream of the single-cycle MIPS datapath and fills its instruction memory from an 8-bit byte stream (UART/host bridge). It parses a length header, packs bytes big-endian into 32-bit instructions, writes them to the instruction memory write port, and verifies a trailing XOR checksum. It holds the core in reset until a load completes cleanly.

## Interface
- IMEM_WORDS, 256: instruction memory depth in words (10-bit byte address space).
- ADDR_W, 10: instruction memory byte-address width.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  byte address of the word being written, always word-aligned.
- imem_wdata  out  32  instruction word.
- busy  out  1  a load is in progress.
- load_done  out  1  last load succeeded; held until next start or reset.
- load_err  out  1  last load failed; held until next start or reset.
- core_reset  out  1  active-high reset to the datapath; low only in DONE.
- words_loaded  out  16  words written in the current or last load.

## Operation
- Stream format: COUNT_HI, COUNT_LO (16-bit word count N, big-endian), then 4·N payload bytes (first byte = instr[31:24]), then one checksum byte = XOR of every preceding byte including both header bytes.
- States: IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start -> HDR_HI; clears load_done, load_err, words_loaded, running XOR, word index; core_reset goes high.
- HDR_HI accept -> HDR_LO. HDR_LO accept -> N > IMEM_WORDS: ERR; N == 0: CSUM; else DATA.
- DATA: each accepted byte shifts into the word assembler; on the 4th byte the word is written to address index·4, index and words_loaded increment; after word N -> CSUM.
- CSUM accept: received byte == running XOR -> DONE, else ERR.
- DONE: load_done=1, core_reset=0. ERR: load_err=1, core_reset=1.
- start while busy is ignored. Bytes offered in IDLE/DONE/ERR are not accepted (in_ready=0).
- Running XOR covers every accepted byte before the checksum byte.

## Timing
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, load_done 0, load_err 0, core_reset 1, words_loaded 0; state IDLE.
- reset_n low mid-load: immediate return to IDLE, partial contents of instruction memory are not cleared, core_reset stays 1.
- Byte transfer occurs on a rising edge with in_valid & in_ready. in_ready is combinational on state only (1 in HDR_HI, HDR_LO, DATA, CSUM); never depends on in_valid.
- One byte per cycle sustained; in_valid gaps stall without losing partial words.
- imem_we, imem_addr, imem_wdata are registered: strobe asserts the cycle after the 4th byte of a word is accepted, for exactly one cycle; addr/data stable during that cycle.
- busy=1 from the cycle after start through the cycle the checksum byte is accepted.
- DONE/ERR and their outputs take effect the cycle after the checksum byte (or the oversize COUNT_LO) is accepted; the final imem_we completes before load_done rises.
- Word index wraps never: N ≤ IMEM_WORDS is enforced by the header check.

## Structure
- Shared package mips_pkg: loader state enum, IMEM_WORDS/ADDR_W defaults, header length constant.
- One sub-module: word_assembler (byte shift register + 2-bit byte counter, emits word_valid and 32-bit word, clear input driven by start).

## Test plan
- N=2, payload 0x20080005, 0x2009000A, correct checksum -> writes 0x20080005@0x000 then 0x2009000A@0x004, load_done=1, core_reset=0, words_loaded=2.
- Same stream with checksum byte flipped -> both words written, load_err=1, core_reset=1, load_done=0.
- Header N=0x0101 (257) -> ERR right after COUNT_LO, no imem_we, in_ready=0.
- N=0 with checksum 0x00 -> DONE, no writes, words_loaded=0.
- N=3 with random in_valid gaps and start pulses mid-load -> identical writes to gap-free run; start ignored.
- reset_n low after 5 payload bytes -> IDLE, all outputs at reset values; fresh start + N=1 stream loads correctly at 0x000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot path: loader state encoding and
// default instruction-memory geometry.
package mips_pkg;

  localparam int DEF_IMEM_WORDS = 256;
  localparam int DEF_ADDR_W     = 10;
  localparam int HDR_BYTES      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; flags the cycle in which
// the fourth byte of a word arrives.
module word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_q;
  logic [1:0]  count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[15:0], byte_in};
      count_q <= count_q + 2'd1;
    end
  end

  // The word is presented together with its last byte so the parent can
  // register it in the same edge that accepts that byte.
  assign word_valid = shift_en && (count_q == 2'd3);
  assign word       = {shift_q, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes instruction words
// into instruction memory and verifies a trailing XOR checksum.
module imem_loader
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = DEF_IMEM_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic              core_reset,
  output logic [15:0]       words_loaded
);

  loader_state_t state_q, state_d;

  logic [15:0] count_q;
  logic [7:0]  xor_q;
  logic        accept;
  logic        start_ok;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] hdr_count;

  assign in_ready  = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                     (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign busy      = in_ready;
  assign accept    = in_valid && in_ready;
  // A start pulse during a load must not disturb it.
  assign start_ok  = start && !busy;
  assign hdr_count = {count_q[15:8], in_data};

  assign load_done  = (state_q == ST_DONE);
  assign load_err   = (state_q == ST_ERR);
  assign core_reset = (state_q != ST_DONE);

  word_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_ok),
    .shift_en   (accept && (state_q == ST_DATA)),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR:
        if (start) state_d = ST_HDR_HI;
      ST_HDR_HI:
        if (accept) state_d = ST_HDR_LO;
      ST_HDR_LO:
        if (accept) begin
          if (hdr_count > 16'(IMEM_WORDS)) state_d = ST_ERR;
          else if (hdr_count == 16'd0)     state_d = ST_CSUM;
          else                             state_d = ST_DATA;
        end
      ST_DATA:
        if (word_valid && (words_loaded + 16'd1 == count_q)) state_d = ST_CSUM;
      ST_CSUM:
        if (accept) state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= '0;
      xor_q        <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        xor_q        <= '0;
        words_loaded <= '0;
      end
      if (accept && (state_q != ST_CSUM)) xor_q <= xor_q ^ in_data;
      if (accept && (state_q == ST_HDR_HI)) count_q[15:8] <= in_data;
      if (accept && (state_q == ST_HDR_LO)) count_q[7:0]  <= in_data;
      if (word_valid) begin
        imem_we      <= 1'b1;
        imem_addr    <= {words_loaded[ADDR_W-3:0], 2'b00};
        imem_wdata   <= word;
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule
